axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter: ID0, default 4'd0, AXI read ID driven on s_arid for requester 0 (icache).
REQ-002 Parameter: ID1, default 4'd1, AXI read ID driven on s_arid for requester 1 (dcache).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 m0_arvalid / m1_arvalid  in  1  requester read-address valid.
REQ-006 m0_araddr / m1_araddr  in  32  requester burst base address.
REQ-007 m0_arready / m1_arready  out  1  requester address accepted.
REQ-008 m0_rready / m1_rready  in  1  requester ready for data.
REQ-009 m0_rvalid / m1_rvalid  out  1  data beat valid to requester.
REQ-010 m0_rdata / m1_rdata  out  32  data beat to requester.
REQ-011 m0_rlast / m1_rlast  out  1  last beat to requester.
REQ-012 s_arvalid  out  1;  s_araddr  out  32;  s_arid  out  4;  s_arready  in  1  memory AR channel.
REQ-013 s_rvalid  in  1;  s_rdata  in  32;  s_rlast  in  1;  s_rid  in  4;  s_rready  out  1  memory R channel.
REQ-014 err  out  1  sticky protocol-error flag.

Function
REQ-015 The block SHALL share one memory read port between two requesters, with at most one outstanding burst.
REQ-016 FSM states SHALL be IDLE, ADDR, DATA.
REQ-017 IDLE: if any mN_arvalid=1, the block SHALL grant one requester, register its araddr into s_araddr, drive s_arid=IDn, assert s_arvalid, and enter ADDR on the next edge (1-cycle request-to-s_arvalid latency).
REQ-018 Both requesting in IDLE: grant SHALL go to the requester not granted last (round-robin); after reset, m0 wins the first tie.
REQ-019 ADDR: s_arvalid, s_araddr and s_arid SHALL stay stable until s_arready=1.
REQ-020 Granted mN_arready SHALL equal s_arvalid & s_arready (single-cycle pulse); the non-granted arready SHALL be 0.
REQ-021 On the AR handshake edge the FSM SHALL enter DATA, deassert s_arvalid, and clear the beat counter.
REQ-022 DATA: s_rvalid, s_rdata, s_rlast SHALL route combinationally to the granted requester; the other requester's rvalid/rlast SHALL be 0 and its rdata 32'b0.
REQ-023 DATA: s_rready SHALL equal the granted mN_rready; s_rready SHALL be 0 in IDLE and ADDR.
REQ-024 A 3-bit beat counter SHALL increment on each s_rvalid & s_rready beat.
REQ-025 Beat with s_rlast=1 and s_rready=1 SHALL return the FSM to IDLE and record the grant for round-robin; next grant no earlier than the following cycle.
REQ-026 err SHALL set, and stay set until reset, if a DATA beat has s_rid != granted ID, or if the 8th beat (counter=7) arrives without s_rlast.
REQ-027 Protocol violations SHALL not alter routing; the burst ends only on s_rlast.
REQ-028 A requester's arvalid deassertion during ADDR SHALL be ignored; the issued request completes.
REQ-029 A new request during ADDR/DATA SHALL wait (mN_arready=0) until IDLE.
REQ-030 s_rvalid in IDLE/ADDR SHALL be ignored (not routed, not counted).

Reset
REQ-031 rst=0 SHALL asynchronously force FSM=IDLE, s_arvalid=0, s_araddr=0, s_arid=0, beat counter=0, err=0, last-grant=m1 (m0 priority).
REQ-032 During reset all outputs SHALL be 0, including combinational arready/rvalid/rlast/rdata/s_rready.
REQ-033 Reset mid-burst SHALL abandon the burst without completing it; no beats are routed after release until a new grant.

Verification
REQ-034 m0 only, araddr=0x0000_1000, s_arready after 2 cycles, 8 beats 0xA0..0xA7 with rlast on 8th -> s_arid=ID0, m0_arready one pulse, m0 receives 8 beats in order, m1_rvalid=0 throughout, err=0.
REQ-035 m0 and m1 assert the same cycle after reset -> m0 granted first; m1 granted next burst with s_arid=ID1, s_araddr=m1_araddr.
REQ-036 Back-to-back simultaneous requests, 4 bursts -> grants alternate m0,m1,m0,m1.
REQ-037 m1 burst with m1_rready toggled 0/1 each cycle -> s_rready mirrors m1_rready, exactly 8 beats counted, FSM to IDLE after rlast.
REQ-038 Burst with s_rid=4'd5 on beat 3 -> err=1 and stays 1; 9-beat burst without rlast by beat 8 -> err=1.
REQ-039 rst=0 asserted in DATA at beat 4 -> all outputs 0 immediately; after release, new m1 request issues normally with err=0.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// axi_rd_arbiter : two-requester round-robin arbiter onto one AXI read port,
//                  one outstanding burst, sticky protocol-error flag.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module axi_rd_arbiter #(
  parameter logic [3:0] ID0 = 4'd0,
  parameter logic [3:0] ID1 = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_arvalid_i,
  input  logic [31:0] m0_araddr_i,
  output logic        m0_arready_o,
  input  logic        m0_rready_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_rlast_o,
  input  logic        m1_arvalid_i,
  input  logic [31:0] m1_araddr_i,
  output logic        m1_arready_o,
  input  logic        m1_rready_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_rlast_o,
  output logic        s_arvalid_o,
  output logic [31:0] s_araddr_o,
  output logic [3:0]  s_arid_o,
  input  logic        s_arready_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  input  logic        s_rlast_i,
  input  logic [3:0]  s_rid_i,
  output logic        s_rready_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;      // 1 = m1 owns the current burst
  logic        last_q, last_d;    // requester that completed the previous burst
  logic        arvalid_q, arvalid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [3:0]  arid_q, arid_d;
  logic [2:0]  beat_q, beat_d;
  logic        err_q, err_d;
  logic        pick;
  logic        in_data;
  logic        beat;

  assign in_data    = (state_q == S_DATA);
  assign s_rready_o = in_data & (gnt_q ? m1_rready_i : m0_rready_i);
  assign beat       = s_rvalid_i & s_rready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'd0;
      arid_q    <= 4'd0;
      beat_q    <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    beat_d    = beat_q;
    err_d     = err_q;
    // On a tie the requester that did not finish the previous burst wins.
    pick      = (m0_arvalid_i && m1_arvalid_i) ? ~last_q : m1_arvalid_i;
    case (state_q)
      S_IDLE: begin
        if (m0_arvalid_i || m1_arvalid_i) begin
          gnt_d     = pick;
          araddr_d  = pick ? m1_araddr_i : m0_araddr_i;
          arid_d    = pick ? ID1 : ID0;
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (s_arready_i) begin
          arvalid_d = 1'b0;
          beat_d    = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          beat_d = beat_q + 3'd1;
          // Errors are only flagged; the burst still ends solely on rlast.
          if ((s_rid_i != arid_q) || ((beat_q == 3'd7) && !s_rlast_i)) begin
            err_d = 1'b1;
          end
          if (s_rlast_i) begin
            last_d  = gnt_q;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign s_arvalid_o  = arvalid_q;
  assign s_araddr_o   = araddr_q;
  assign s_arid_o     = arid_q;
  assign err_o        = err_q;

  assign m0_arready_o = arvalid_q & s_arready_i & ~gnt_q;
  assign m1_arready_o = arvalid_q & s_arready_i & gnt_q;

  assign m0_rvalid_o  = in_data & ~gnt_q & s_rvalid_i;
  assign m0_rlast_o   = in_data & ~gnt_q & s_rlast_i;
  assign m0_rdata_o   = (in_data & ~gnt_q) ? s_rdata_i : 32'd0;
  assign m1_rvalid_o  = in_data & gnt_q & s_rvalid_i;
  assign m1_rlast_o   = in_data & gnt_q & s_rlast_i;
  assign m1_rdata_o   = (in_data & gnt_q) ? s_rdata_i : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// tb_axi_rd_arbiter : directed scoreboard bench for axi_rd_arbiter.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_axi_rd_arbiter;

  localparam logic [3:0] ID0 = 4'd2;
  localparam logic [3:0] ID1 = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, err;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;

  int          checks = 0;
  int          errors = 0;
  bit          last_g;
  bit          exp_err;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ID0(ID0), .ID1(ID1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid_i(m0_arvalid), .m0_araddr_i(m0_araddr), .m0_arready_o(m0_arready),
    .m0_rready_i(m0_rready), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m0_rlast_o(m0_rlast),
    .m1_arvalid_i(m1_arvalid), .m1_araddr_i(m1_araddr), .m1_arready_o(m1_arready),
    .m1_rready_i(m1_rready), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .m1_rlast_o(m1_rlast),
    .s_arvalid_o(s_arvalid), .s_araddr_o(s_araddr), .s_arid_o(s_arid),
    .s_arready_i(s_arready), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .s_rlast_i(s_rlast), .s_rid_i(s_rid), .s_rready_o(s_rready), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All outputs must be zero while reset is asserted, whatever the inputs do.
  task automatic rst_outputs_zero(input string tag);
    chk({tag, "_flags"}, {20'd0, s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid,
                          m0_rlast, m1_rlast, s_rready, err, 3'd0}, 32'd0);
    chk({tag, "_araddr"}, s_araddr, 32'd0);
    chk({tag, "_arid"}, {28'd0, s_arid}, 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    rst_outputs_zero(tag);
    tick();
    rst_n   = 1'b1;
    last_g  = 1'b1;
    exp_err = 1'b0;
    sb.delete();
  endtask

  task automatic burst(input bit r0, input bit r1, input logic [31:0] a0,
                       input logic [31:0] a1, input int ar_dly, input int nbeats,
                       input int bad_beat, input bit toggle, input int abort_at);
    bit          g;
    bit          rr;
    logic [31:0] ea;
    logic [3:0]  eid;
    logic [32:0] exp;
    int          bc;
    int          seen;
    g   = (r0 && r1) ? ~last_g : r1;
    ea  = g ? a1 : a0;
    eid = g ? ID1 : ID0;

    m0_arvalid = r0; m1_arvalid = r1; m0_araddr = a0; m1_araddr = a1;
    #1;
    chk("idle_arvalid", {31'd0, s_arvalid}, 32'd0);
    chk("idle_arready", {30'd0, m0_arready, m1_arready}, 32'd0);
    tick();
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_araddr = ~a0; m1_araddr = ~a1;
    for (int i = 0; i < ar_dly; i++) begin
      #1;
      chk("addr_arvalid", {31'd0, s_arvalid}, 32'd1);
      chk("addr_araddr", s_araddr, ea);
      chk("addr_arid", {28'd0, s_arid}, {28'd0, eid});
      chk("addr_arready_wait", {30'd0, m0_arready, m1_arready}, 32'd0);
      tick();
    end
    s_arready = 1'b1;
    #1;
    chk("hs_araddr", s_araddr, ea);
    chk("hs_arid", {28'd0, s_arid}, {28'd0, eid});
    chk("hs_arready", {30'd0, m0_arready, m1_arready}, g ? 32'd1 : 32'd2);
    chk("addr_srready", {31'd0, s_rready}, 32'd0);
    tick();
    s_arready = 1'b0;
    #1;
    chk("data_arvalid", {31'd0, s_arvalid}, 32'd0);

    bc   = 0;
    seen = 0;
    for (int cyc = 0; cyc < 4 * nbeats + 4 && bc < nbeats; cyc++) begin
      s_rvalid = 1'b1;
      s_rdata  = 32'hA0 + bc + (g ? 32'h100 : 32'h0);
      s_rlast  = (bc == nbeats - 1);
      s_rid    = (bc == bad_beat) ? 4'd5 : eid;
      if (bc == abort_at) begin
        do_reset("abort");
        #1;
        chk("post_abort_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
        chk("post_abort_srready", {31'd0, s_rready}, 32'd0);
        s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
        return;
      end
      rr = toggle ? (cyc % 2 == 1) : 1'b1;
      if (g) begin m1_rready = rr; m0_rready = 1'b1; end
      else   begin m0_rready = rr; m1_rready = 1'b1; end
      if (rr) sb.push_back({s_rlast, s_rdata});
      #1;
      chk("srready_mirror", {31'd0, s_rready}, {31'd0, rr});
      chk("err_flag", {31'd0, err}, {31'd0, exp_err});
      chk("other_rvalid", {30'd0, g ? m0_rvalid : m1_rvalid, g ? m0_rlast : m1_rlast}, 32'd0);
      chk("other_rdata", g ? m0_rdata : m1_rdata, 32'd0);
      chk("data_arready", {30'd0, m0_arready, m1_arready}, 32'd0);
      if (g ? m1_rvalid : m0_rvalid) begin
        if (rr) seen++;
      end else begin
        chk("gnt_rvalid", 32'd0, 32'd1);
      end
      if (rr) begin
        exp = sb.pop_front();
        chk("beat_rdata", g ? m1_rdata : m0_rdata, exp[31:0]);
        chk("beat_rlast", {31'd0, g ? m1_rlast : m0_rlast}, {31'd0, exp[32]});
        if ((s_rid != eid) || (bc == 7 && !s_rlast)) exp_err = 1'b1;
        bc++;
      end
      tick();
    end
    last_g = g;
    chk("beats_seen", seen, nbeats);
    // Back in IDLE: a stray rvalid must be neither routed nor accepted.
    s_rvalid = 1'b1; s_rlast = 1'b0; m0_rready = 1'b1; m1_rready = 1'b1;
    #1;
    chk("idle_srready", {31'd0, s_rready}, 32'd0);
    chk("idle_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("end_err", {31'd0, err}, {31'd0, exp_err});
    s_rvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_araddr = 32'd0; m1_araddr = 32'd0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF; s_rlast = 1'b1; s_rid = 4'd0;
    last_g = 1'b1; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_outputs_zero("reset");
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    rst_n = 1'b1;
    tick();

    // m0 alone, 2-cycle arready delay, eight beats 0xA0..0xA7
    burst(1, 0, 32'h0000_1000, 32'h0, 2, 8, -1, 0, -1);

    // simultaneous requests right after reset, then alternating ties
    do_reset("rst2");
    burst(1, 1, 32'h0000_2000, 32'h0000_3000, 1, 8, -1, 0, -1);
    burst(1, 1, 32'h0000_2100, 32'h0000_3100, 0, 4, -1, 0, -1);
    burst(1, 1, 32'h0000_2200, 32'h0000_3200, 3, 2, -1, 0, -1);
    burst(1, 1, 32'h0000_2300, 32'h0000_3300, 1, 1, -1, 0, -1);

    // m1 with rready toggling each cycle
    burst(0, 1, 32'h0, 32'h0000_4000, 1, 8, -1, 1, -1);

    // bad rid on beat 3, then err must stay set through a clean burst
    burst(1, 0, 32'h0000_5000, 32'h0, 1, 8, 3, 0, -1);
    burst(0, 1, 32'h0, 32'h0000_5100, 1, 4, -1, 0, -1);

    // nine-beat burst: beat 8 arrives without rlast
    do_reset("rst3");
    burst(0, 1, 32'h0, 32'h0000_6000, 1, 9, -1, 0, -1);

    // reset in the middle of a burst, then a fresh m1 request
    burst(1, 0, 32'h0000_7000, 32'h0, 1, 8, -1, 0, 4);
    burst(0, 1, 32'h0, 32'h0000_8000, 2, 8, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
